dual_grant_arbiter: RTL and testbench
=====================================

Name: dual_grant_arbiter

Overview:
- Shares two identical resource slots (A, B) among 15 requesters indexed 15..1. Index 0 means "no grant", matching the team's 15-bit dual priority encoder convention.
- Each cycle it picks the top two eligible requesters in a rotating-priority order. Each grant is held until the requester releases it or a hold timeout expires.
- It sits between the request collectors and the two-slot shared datapath, and replaces the fixed-priority dual encoder wherever fairness is required.

Parameters:
- HOLD_MAX, 8: maximum consecutive cycles a slot may stay granted to one requester. 0 = unlimited; legal range 0..255.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- req, input, [15:1]: level requests; req[i]=1 means requester i wants a slot.
- grant_a, output, [3:0]: index holding slot A; 0 = slot A idle.
- grant_b, output, [3:0]: index holding slot B; 0 = slot B idle.
- grant_vec, output, [15:1]: one bit per requester, set while that requester holds either slot.
- timeout, output, 1: one-cycle pulse when a slot is revoked by hold timeout.
- timeout_idx, output, [3:0]: index revoked with the timeout pulse; 0 when timeout=0.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - grant_a=0, grant_b=0, grant_vec=0, timeout=0, timeout_idx=0.
  - Both slots IDLE, hold counters 0, rotation pointer ptr=15.
- All outputs are registered. A grant decided at edge N is visible after edge N.
- Slot FSM, per slot, states IDLE and BUSY:
  - IDLE -> BUSY: the slot is allocated a candidate at this edge. Counter loads 1.
  - BUSY -> BUSY: req[idx]=1 and (HOLD_MAX=0 or counter<HOLD_MAX). Counter increments; it saturates when HOLD_MAX=0.
  - BUSY -> IDLE (release): req[idx]=0 at the edge.
  - BUSY -> IDLE (revoke): req[idx]=1 and counter==HOLD_MAX. At the same edge, timeout=1 and timeout_idx=idx for one cycle.
  - A slot that leaves BUSY at edge N is not eligible for allocation until edge N+1. This gives a one-cycle idle bubble.
- Eligibility:
  - eligible = req & ~grant_vec (current registered value).
  - A requester never holds both slots.
  - A requester released or revoked at edge N may be re-granted from edge N+1.
- Search order: ptr, ptr-1, ..., 1, 15, 14, ..., ptr+1. With ptr=15 this is plain descending priority (15 highest).
- Allocation at each edge, over eligible requesters in search order:
  - Both slots IDLE: first candidate -> A, second -> B. Only one candidate: it goes to A.
  - Only one slot IDLE: first candidate -> that slot.
  - No IDLE slot or no candidate: no allocation.
- Pointer update:
  - When at least one grant is allocated at an edge, ptr becomes the position immediately after the last allocated index in search order: idx-1, and idx=1 wraps to 15.
  - On a revoke with no allocation at that edge, ptr becomes revoked_idx-1 (wrap 1->15), so the revoked requester drops to lowest priority.
  - If an allocation and a revoke happen at the same edge, the allocation rule wins.
  - Otherwise ptr holds.
- Simultaneous events:
  - Both slots may release or revoke at the same edge.
  - If both revoke at once: timeout_idx reports slot A's index, and ptr uses slot B's index.
- grant_vec is the registered OR of the decoded grant_a and grant_b. It has at most two bits set.
- Glitch-free requirement: req changing while a slot is BUSY for a different index has no effect on that slot.

Test Plan:
- Reset, then req=15'h7FFF held -> after edge 1: grant_a=15, grant_b=14, grant_vec bits 15 and 14 set, ptr=13.
- Continue from previous state: drop req[15] for one cycle -> slot A goes IDLE (grant_a=0) for one cycle, then grant_a=13, ptr=12.
- HOLD_MAX=8; only req[5] held high from reset -> grant_a=5 for cycles 1..8. At edge 9: grant_a=0, timeout=1, timeout_idx=5. At edge 10: grant_a=5 again.
- req[3] and req[2] held high, HOLD_MAX=4 -> A=3, B=2. Both revoke on the same edge with timeout_idx=3. Next edge re-grants A=3, B=2 with ptr wrapped to 1 first. Check fairness ordering against the model.
- Assert rst_n=0 mid-hold with A=7, B=6 -> outputs clear immediately without waiting for a clock edge. After release with req unchanged, the first grant is A=7, B=6 (ptr=15).
- HOLD_MAX=0, req[1] held for 300 cycles -> grant_a=1 throughout, timeout never asserts, and the counter does not wrap.

Source files
------------

// File: rtl/dual_grant_arbiter_if.sv
// ============================================================================
// Module   : dual_grant_arbiter_if
// Purpose  : Request / grant bundle between the request collectors and the
//            two-slot rotating-priority arbiter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface dual_grant_arbiter_if;
    logic [15:1] req;
    logic [3:0]  grant_a;
    logic [3:0]  grant_b;
    logic [15:1] grant_vec;
    logic        timeout;
    logic [3:0]  timeout_idx;

    modport master (
        output req,
        input  grant_a, grant_b, grant_vec, timeout, timeout_idx
    );

    modport slave (
        input  req,
        output grant_a, grant_b, grant_vec, timeout, timeout_idx
    );
endinterface

`default_nettype wire

// File: rtl/dual_grant_arbiter.sv
// ============================================================================
// Module   : dual_grant_arbiter
// Purpose  : Grants two shared slots to 15 requesters in rotating priority,
//            with per-slot hold timeout and registered outputs.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dual_grant_arbiter #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    dual_grant_arbiter_if.slave bus
);
    localparam logic [0:0] c_idle      = 1'b0;
    localparam logic [0:0] c_busy      = 1'b1;
    localparam logic [7:0] c_hold_max  = 8'(HOLD_MAX);
    localparam logic [0:0] c_unlimited = 1'(HOLD_MAX == 0);

    // Slot 0 is A, slot 1 is B.
    logic [0:0]  r_state [2];
    logic [3:0]  r_idx   [2];
    logic [7:0]  r_cnt   [2];
    logic [3:0]  r_ptr;
    logic [15:1] r_grant_vec;
    logic        r_timeout;
    logic [3:0]  r_timeout_idx;

    logic [0:0]  w_state_nxt [2];
    logic [3:0]  w_idx_nxt   [2];
    logic [7:0]  w_cnt_nxt   [2];
    logic [3:0]  w_alloc_idx [2];
    logic [1:0]  w_busy;
    logic [1:0]  w_held;
    logic [1:0]  w_release;
    logic [1:0]  w_revoke;
    logic [1:0]  w_alloc;
    logic [15:0] w_req_ext;
    logic [15:1] w_eligible;
    logic [3:0]  w_pos;
    logic [3:0]  w_first;
    logic [3:0]  w_second;
    logic        w_first_vld;
    logic        w_second_vld;
    logic [3:0]  w_last_idx;
    logic [3:0]  w_ptr_nxt;
    logic [15:1] w_grant_vec_nxt;
    logic        w_timeout_nxt;
    logic [3:0]  w_timeout_idx_nxt;

    function automatic logic [3:0] prev_idx(input logic [3:0] idx);
        return (idx <= 4'd1) ? 4'd15 : idx - 4'd1;
    endfunction

    function automatic logic [15:1] onehot(input logic [3:0] idx);
        logic [15:0] t;
        t = 16'd1 << idx;
        return t[15:1];
    endfunction

    // Bit 0 is a constant zero so an idle slot (index 0) never reads as held.
    assign w_req_ext  = {bus.req, 1'b0};
    assign w_eligible = bus.req & ~r_grant_vec;

    always_comb begin
        w_first      = 4'd0;
        w_second     = 4'd0;
        w_first_vld  = 1'b0;
        w_second_vld = 1'b0;
        w_pos        = r_ptr;
        for (int k = 0; k < 15; k++) begin
            if (w_eligible[w_pos]) begin
                if (!w_first_vld) begin
                    w_first     = w_pos;
                    w_first_vld = 1'b1;
                end else if (!w_second_vld) begin
                    w_second     = w_pos;
                    w_second_vld = 1'b1;
                end
            end
            w_pos = prev_idx(w_pos);
        end

        w_alloc        = 2'b00;
        w_alloc_idx[0] = 4'd0;
        w_alloc_idx[1] = 4'd0;
        if (r_state[0] == c_idle && r_state[1] == c_idle) begin
            w_alloc[0]     = w_first_vld;
            w_alloc_idx[0] = w_first;
            w_alloc[1]     = w_second_vld;
            w_alloc_idx[1] = w_second;
        end else if (r_state[0] == c_idle) begin
            w_alloc[0]     = w_first_vld;
            w_alloc_idx[0] = w_first;
        end else if (r_state[1] == c_idle) begin
            w_alloc[1]     = w_first_vld;
            w_alloc_idx[1] = w_first;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_slot
        assign w_busy[g]    = (r_state[g] == c_busy);
        assign w_held[g]    = w_req_ext[r_idx[g]];
        assign w_release[g] = w_busy[g] && !w_held[g];
        assign w_revoke[g]  = w_busy[g] && w_held[g] && !c_unlimited &&
                              (r_cnt[g] == c_hold_max);

        always_comb begin
            w_state_nxt[g] = r_state[g];
            w_idx_nxt[g]   = r_idx[g];
            w_cnt_nxt[g]   = r_cnt[g];
            case (r_state[g])
                c_idle: begin
                    if (w_alloc[g]) begin
                        w_state_nxt[g] = c_busy;
                        w_idx_nxt[g]   = w_alloc_idx[g];
                        w_cnt_nxt[g]   = 8'd1;
                    end
                end
                default: begin
                    if (w_release[g] || w_revoke[g]) begin
                        w_state_nxt[g] = c_idle;
                        w_idx_nxt[g]   = 4'd0;
                        w_cnt_nxt[g]   = 8'd0;
                    end else if (r_cnt[g] != 8'hFF) begin
                        // Only reachable past HOLD_MAX when unlimited; saturates.
                        w_cnt_nxt[g] = r_cnt[g] + 8'd1;
                    end
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state[g] <= c_idle;
                r_idx[g]   <= 4'd0;
                r_cnt[g]   <= 8'd0;
            end else begin
                r_state[g] <= w_state_nxt[g];
                r_idx[g]   <= w_idx_nxt[g];
                r_cnt[g]   <= w_cnt_nxt[g];
            end
        end
    end

    always_comb begin
        w_last_idx = w_alloc[1] ? w_alloc_idx[1] : w_alloc_idx[0];
        w_ptr_nxt  = r_ptr;
        if (|w_alloc) begin
            w_ptr_nxt = prev_idx(w_last_idx);
        end else if (w_revoke[1]) begin
            w_ptr_nxt = prev_idx(r_idx[1]);
        end else if (w_revoke[0]) begin
            w_ptr_nxt = prev_idx(r_idx[0]);
        end
        w_timeout_nxt     = |w_revoke;
        w_timeout_idx_nxt = w_revoke[0] ? r_idx[0] :
                            w_revoke[1] ? r_idx[1] : 4'd0;
        w_grant_vec_nxt   = onehot(w_idx_nxt[0]) | onehot(w_idx_nxt[1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr         <= 4'd15;
            r_grant_vec   <= '0;
            r_timeout     <= 1'b0;
            r_timeout_idx <= 4'd0;
        end else begin
            r_ptr         <= w_ptr_nxt;
            r_grant_vec   <= w_grant_vec_nxt;
            r_timeout     <= w_timeout_nxt;
            r_timeout_idx <= w_timeout_idx_nxt;
        end
    end

    assign bus.grant_a     = r_idx[0];
    assign bus.grant_b     = r_idx[1];
    assign bus.grant_vec   = r_grant_vec;
    assign bus.timeout     = r_timeout;
    assign bus.timeout_idx = r_timeout_idx;

endmodule

`default_nettype wire

// File: tb/tb_dual_grant_arbiter.sv
// ============================================================================
// Module   : tb_dual_grant_arbiter
// Purpose  : Directed self-checking bench for dual_grant_arbiter at
//            HOLD_MAX = 8, 4 and 0.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dual_grant_arbiter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    dual_grant_arbiter_if bus8 ();
    dual_grant_arbiter_if bus4 ();
    dual_grant_arbiter_if bus0 ();

    dual_grant_arbiter #(.HOLD_MAX(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    dual_grant_arbiter #(.HOLD_MAX(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    dual_grant_arbiter #(.HOLD_MAX(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset();
        rst_n    = 1'b0;
        bus8.req = '0;
        bus4.req = '0;
        bus0.req = '0;
        tick();
        tick();
    endtask

    task automatic check_ab(input string tag, input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] ea, input logic [3:0] eb);
        check({tag, "_a"}, 32'(a), 32'(ea));
        check({tag, "_b"}, 32'(b), 32'(eb));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state and plain descending priority.
        hold_reset();
        check_ab("rst", bus8.grant_a, bus8.grant_b, 4'd0, 4'd0);
        check("rst_vec", 32'(bus8.grant_vec), 32'h0);
        check("rst_to", 32'(bus8.timeout), 32'h0);
        check("rst_toidx", 32'(bus8.timeout_idx), 32'h0);
        check("rst_ptr", 32'(dut8.r_ptr), 32'd15);

        bus8.req = 15'h7FFF;
        rst_n    = 1'b1;
        tick();
        check_ab("all_e1", bus8.grant_a, bus8.grant_b, 4'd15, 4'd14);
        check("all_e1_vec", 32'(bus8.grant_vec), 32'h6000);
        check("all_e1_ptr", 32'(dut8.r_ptr), 32'd13);
        bus8.req[15] = 1'b0;
        tick();
        check_ab("drop15", bus8.grant_a, bus8.grant_b, 4'd0, 4'd14);
        check("drop15_vec", 32'(bus8.grant_vec), 32'h2000);
        bus8.req = 15'h7FFF;
        tick();
        check_ab("regrant13", bus8.grant_a, bus8.grant_b, 4'd13, 4'd14);
        check("regrant13_vec", 32'(bus8.grant_vec), 32'h3000);
        check("regrant13_ptr", 32'(dut8.r_ptr), 32'd12);

        // Single requester hits the HOLD_MAX=8 timeout.
        hold_reset();
        bus8.req = 15'h0010;
        rst_n    = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("hold5_a", 32'(bus8.grant_a), 32'd5);
            check("hold5_to", 32'(bus8.timeout), 32'd0);
        end
        tick();
        check("rev5_a", 32'(bus8.grant_a), 32'd0);
        check("rev5_to", 32'(bus8.timeout), 32'd1);
        check("rev5_toidx", 32'(bus8.timeout_idx), 32'd5);
        check("rev5_ptr", 32'(dut8.r_ptr), 32'd4);
        tick();
        check("again5_a", 32'(bus8.grant_a), 32'd5);
        check("again5_to", 32'(bus8.timeout), 32'd0);
        check("again5_toidx", 32'(bus8.timeout_idx), 32'd0);
        check("again5_ptr", 32'(dut8.r_ptr), 32'd4);

        // Dual revoke with HOLD_MAX=4 and rotation fairness.
        hold_reset();
        bus4.req = 15'h0006;
        rst_n    = 1'b1;
        tick();
        check_ab("d_e1", bus4.grant_a, bus4.grant_b, 4'd3, 4'd2);
        check("d_e1_ptr", 32'(dut4.r_ptr), 32'd1);
        tick(); tick(); tick();
        check_ab("d_e4", bus4.grant_a, bus4.grant_b, 4'd3, 4'd2);
        check("d_e4_to", 32'(bus4.timeout), 32'd0);
        tick();
        check_ab("d_e5", bus4.grant_a, bus4.grant_b, 4'd0, 4'd0);
        check("d_e5_to", 32'(bus4.timeout), 32'd1);
        check("d_e5_toidx", 32'(bus4.timeout_idx), 32'd3);
        check("d_e5_ptr", 32'(dut4.r_ptr), 32'd1);
        tick();
        check_ab("d_e6", bus4.grant_a, bus4.grant_b, 4'd3, 4'd2);
        check("d_e6_to", 32'(bus4.timeout), 32'd0);
        bus4.req = 15'h000E;
        tick(); tick(); tick();
        check_ab("d_e9", bus4.grant_a, bus4.grant_b, 4'd3, 4'd2);
        tick();
        check("d_e10_to", 32'(bus4.timeout), 32'd1);
        check("d_e10_toidx", 32'(bus4.timeout_idx), 32'd3);
        tick();
        check_ab("d_e11", bus4.grant_a, bus4.grant_b, 4'd4, 4'd3);
        check("d_e11_ptr", 32'(dut4.r_ptr), 32'd2);
        tick(); tick(); tick(); tick();
        check_ab("d_e15", bus4.grant_a, bus4.grant_b, 4'd0, 4'd0);
        check("d_e15_toidx", 32'(bus4.timeout_idx), 32'd4);
        check("d_e15_ptr", 32'(dut4.r_ptr), 32'd2);
        tick();
        check_ab("d_e16", bus4.grant_a, bus4.grant_b, 4'd2, 4'd4);
        check("d_e16_vec", 32'(bus4.grant_vec), 32'h000A);
        check("d_e16_ptr", 32'(dut4.r_ptr), 32'd3);

        // Asynchronous reset mid-hold.
        hold_reset();
        bus8.req = 15'h0060;
        rst_n    = 1'b1;
        tick();
        check_ab("ar_e1", bus8.grant_a, bus8.grant_b, 4'd7, 4'd6);
        tick(); tick();
        #3;
        rst_n = 1'b0;
        #1;
        check_ab("ar_async", bus8.grant_a, bus8.grant_b, 4'd0, 4'd0);
        check("ar_async_vec", 32'(bus8.grant_vec), 32'h0);
        check("ar_async_ptr", 32'(dut8.r_ptr), 32'd15);
        tick();
        rst_n = 1'b1;
        tick();
        check_ab("ar_regrant", bus8.grant_a, bus8.grant_b, 4'd7, 4'd6);
        check("ar_regrant_vec", 32'(bus8.grant_vec), 32'h0060);

        // Unlimited hold: no timeout, counter saturates.
        hold_reset();
        bus0.req = 15'h0001;
        rst_n    = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            check("unl_a", 32'(bus0.grant_a), 32'd1);
            check("unl_to", 32'(bus0.timeout), 32'd0);
        end
        check("unl_b", 32'(bus0.grant_b), 32'd0);
        check("unl_cnt", 32'(dut0.r_cnt[0]), 32'd255);
        check("unl_ptr", 32'(dut0.r_ptr), 32'd15);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
